uv_bus_arb_2x1: RTL and testbench



---
 rtl/uv_bus_pkg.sv | 15 +
 rtl/uv_bus_arb_idq.sv | 69 ++++++
 rtl/uv_bus_arb_2x1.sv | 129 ++++++++++++
 tb/tb_uv_bus_arb_2x1.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uv_bus_pkg.sv
// Shared definitions for the uv_bus fabric blocks.
//   - excp_e / EXCP_*: 2-bit response exception encodings carried on *_rsp_excp.
//   - MID_W: width of a master ID as tracked by the 2x1 arbiter's ID queue.
package uv_bus_pkg;

  typedef enum logic [1:0] {
    EXCP_NONE      = 2'b00,
    EXCP_ACC_FAULT = 2'b01,
    EXCP_MISALIGN  = 2'b10,
    EXCP_PAGE_FLT  = 2'b11
  } excp_e;

  localparam int MID_W = 1;

endpackage

// File: rtl/uv_bus_arb_idq.sv
// In-order ID FIFO: remembers which master issued each outstanding request
// so responses can be routed back in issue order.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push/push_id enqueue an ID (ignored when full)
//   pop          dequeue the head (ignored when empty)
//   head_id      oldest ID (meaningful only when !empty)
//   full/empty   occupancy flags
module uv_bus_arb_idq #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_id = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/uv_bus_arb_2x1.sv
// Two-master to one-port bus arbiter. Round-robin grant with locking while a
// granted request stalls; an in-order ID queue routes each response back to
// its issuer. Request/response paths are combinational.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mst{0,1}_req_*      request channel from each master (vld/rdy/read/addr/mask/data)
//   mst{0,1}_rsp_*      response channel to each master (vld/rdy/excp/data)
//   slv_req_*           request channel to the fabric master port
//   slv_rsp_*           response channel from the fabric
module uv_bus_arb_2x1
  import uv_bus_pkg::*;
#(
  parameter int ALEN     = 32,
  parameter int DLEN     = 32,
  parameter int MLEN     = DLEN / 8,
  parameter int OSTD_NUM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mst0_req_vld,
  output logic            mst0_req_rdy,
  input  logic            mst0_req_read,
  input  logic [ALEN-1:0] mst0_req_addr,
  input  logic [MLEN-1:0] mst0_req_mask,
  input  logic [DLEN-1:0] mst0_req_data,
  output logic            mst0_rsp_vld,
  input  logic            mst0_rsp_rdy,
  output logic [1:0]      mst0_rsp_excp,
  output logic [DLEN-1:0] mst0_rsp_data,
  input  logic            mst1_req_vld,
  output logic            mst1_req_rdy,
  input  logic            mst1_req_read,
  input  logic [ALEN-1:0] mst1_req_addr,
  input  logic [MLEN-1:0] mst1_req_mask,
  input  logic [DLEN-1:0] mst1_req_data,
  output logic            mst1_rsp_vld,
  input  logic            mst1_rsp_rdy,
  output logic [1:0]      mst1_rsp_excp,
  output logic [DLEN-1:0] mst1_rsp_data,
  output logic            slv_req_vld,
  input  logic            slv_req_rdy,
  output logic            slv_req_read,
  output logic [ALEN-1:0] slv_req_addr,
  output logic [MLEN-1:0] slv_req_mask,
  output logic [DLEN-1:0] slv_req_data,
  input  logic            slv_rsp_vld,
  output logic            slv_rsp_rdy,
  input  logic [1:0]      slv_rsp_excp,
  input  logic [DLEN-1:0] slv_rsp_data
);

  logic             rr_ptr_q, rr_ptr_d;
  logic             lock_vld_q, lock_vld_d;
  logic             lock_id_q, lock_id_d;
  logic             gnt;
  logic             req_hs, rsp_pop;
  logic             q_full, q_empty;
  logic [MID_W-1:0] head;
  logic             route0, route1;

  // A stalled grant is held so the fabric sees a stable request.
  always_comb begin
    gnt = 1'b0;
    if (lock_vld_q)                      gnt = lock_id_q;
    else if (mst0_req_vld & mst1_req_vld) gnt = rr_ptr_q;
    else                                  gnt = mst1_req_vld;
  end

  assign slv_req_vld  = (gnt ? mst1_req_vld : mst0_req_vld) & ~q_full;
  assign slv_req_read = gnt ? mst1_req_read : mst0_req_read;
  assign slv_req_addr = gnt ? mst1_req_addr : mst0_req_addr;
  assign slv_req_mask = gnt ? mst1_req_mask : mst0_req_mask;
  assign slv_req_data = gnt ? mst1_req_data : mst0_req_data;
  assign mst0_req_rdy = ~gnt & slv_req_rdy & ~q_full;
  assign mst1_req_rdy =  gnt & slv_req_rdy & ~q_full;
  assign req_hs       = slv_req_vld & slv_req_rdy;

  // Responses with an empty queue are spurious: accept and drop them.
  assign route0        = ~q_empty & (head == MID_W'(0));
  assign route1        = ~q_empty & (head == MID_W'(1));
  assign mst0_rsp_vld  = route0 & slv_rsp_vld;
  assign mst1_rsp_vld  = route1 & slv_rsp_vld;
  assign mst0_rsp_excp = route0 ? slv_rsp_excp : 2'b00;
  assign mst1_rsp_excp = route1 ? slv_rsp_excp : 2'b00;
  assign mst0_rsp_data = route0 ? slv_rsp_data : '0;
  assign mst1_rsp_data = route1 ? slv_rsp_data : '0;
  assign slv_rsp_rdy   = q_empty | (route0 & mst0_rsp_rdy) | (route1 & mst1_rsp_rdy);
  assign rsp_pop       = slv_rsp_vld & slv_rsp_rdy & ~q_empty;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (req_hs) begin
      rr_ptr_d   = ~gnt;
      lock_vld_d = 1'b0;
    end else if (slv_req_vld) begin
      lock_vld_d = 1'b1;
      lock_id_d  = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end

  uv_bus_arb_idq #(
    .WIDTH (MID_W),
    .DEPTH (OSTD_NUM)
  ) u_idq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (req_hs),
    .push_id (gnt),
    .pop     (rsp_pop),
    .head_id (head),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_uv_bus_arb_2x1.sv
// Randomized bench for uv_bus_arb_2x1 against a transaction-level model:
// an outstanding-owner queue, a favoured-master number and a stalled-owner
// number, all updated from the observed handshakes.
module tb_uv_bus_arb_2x1;
  localparam int ALEN = 32;
  localparam int DLEN = 32;
  localparam int MLEN = 4;
  localparam int OSTD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            mv [2];
  logic            mrd[2];
  logic [ALEN-1:0] ma [2];
  logic [MLEN-1:0] mm [2];
  logic [DLEN-1:0] md [2];
  logic            mrr[2];
  logic            mst0_req_rdy, mst1_req_rdy, mst0_rsp_vld, mst1_rsp_vld;
  logic [1:0]      mst0_rsp_excp, mst1_rsp_excp;
  logic [DLEN-1:0] mst0_rsp_data, mst1_rsp_data;
  logic            slv_req_vld, slv_req_rdy, slv_req_read;
  logic [ALEN-1:0] slv_req_addr;
  logic [MLEN-1:0] slv_req_mask;
  logic [DLEN-1:0] slv_req_data;
  logic            slv_rsp_vld, slv_rsp_rdy;
  logic [1:0]      slv_rsp_excp;
  logic [DLEN-1:0] slv_rsp_data;

  uv_bus_arb_2x1 #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN), .OSTD_NUM(OSTD)) dut (
    .clk(clk), .rst_n(rst_n),
    .mst0_req_vld(mv[0]), .mst0_req_rdy(mst0_req_rdy), .mst0_req_read(mrd[0]),
    .mst0_req_addr(ma[0]), .mst0_req_mask(mm[0]), .mst0_req_data(md[0]),
    .mst0_rsp_vld(mst0_rsp_vld), .mst0_rsp_rdy(mrr[0]),
    .mst0_rsp_excp(mst0_rsp_excp), .mst0_rsp_data(mst0_rsp_data),
    .mst1_req_vld(mv[1]), .mst1_req_rdy(mst1_req_rdy), .mst1_req_read(mrd[1]),
    .mst1_req_addr(ma[1]), .mst1_req_mask(mm[1]), .mst1_req_data(md[1]),
    .mst1_rsp_vld(mst1_rsp_vld), .mst1_rsp_rdy(mrr[1]),
    .mst1_rsp_excp(mst1_rsp_excp), .mst1_rsp_data(mst1_rsp_data),
    .slv_req_vld(slv_req_vld), .slv_req_rdy(slv_req_rdy), .slv_req_read(slv_req_read),
    .slv_req_addr(slv_req_addr), .slv_req_mask(slv_req_mask), .slv_req_data(slv_req_data),
    .slv_rsp_vld(slv_rsp_vld), .slv_rsp_rdy(slv_rsp_rdy),
    .slv_rsp_excp(slv_rsp_excp), .slv_rsp_data(slv_rsp_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int fav;        // master preferred when both request
  int stalled;    // master whose request the fabric is stalling, -1 if none
  int owner[$];   // issuers of outstanding requests, oldest first
  bit hold[2];    // master must keep its request stable this cycle

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fav = 0;
    stalled = -1;
    owner.delete();
    hold[0] = 1'b0;
    hold[1] = 1'b0;
  endtask

  task automatic all_low();
    for (int x = 0; x < 2; x++) begin
      mv[x] = 1'b0; mrd[x] = 1'b0; ma[x] = '0; mm[x] = '0; md[x] = '0; mrr[x] = 1'b0;
    end
    slv_req_rdy = 1'b0; slv_rsp_vld = 1'b0; slv_rsp_excp = 2'b00; slv_rsp_data = '0;
  endtask

  // With all inputs low, only slv_rsp_rdy is high (the queue is empty).
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, 128'({mst0_req_rdy, mst1_req_rdy, mst0_rsp_vld, mst1_rsp_vld,
                             mst0_rsp_excp, mst1_rsp_excp, slv_req_vld, slv_req_read,
                             slv_rsp_rdy, slv_req_mask}), 128'h10);
    chk({tag, "_req"}, 128'({slv_req_addr, slv_req_data}), 128'h0);
    chk({tag, "_rsp"}, 128'({mst0_rsp_data, mst1_rsp_data}), 128'h0);
  endtask

  // Percent knobs: master valid, fabric req ready, fabric rsp valid, master rsp ready.
  task automatic drive(input int pv, input int ps, input int prv, input int prr);
    for (int x = 0; x < 2; x++) begin
      if (!hold[x]) begin
        mv[x]  = ($urandom % 100) < pv;
        mrd[x] = 1'($urandom);
        ma[x]  = $urandom;
        mm[x]  = 4'($urandom);
        md[x]  = $urandom;
      end
      mrr[x] = ($urandom % 100) < prr;
    end
    slv_req_rdy  = ($urandom % 100) < ps;
    slv_rsp_vld  = ($urandom % 100) < prv;
    slv_rsp_excp = 2'($urandom);
    slv_rsp_data = $urandom;
  endtask

  task automatic step();
    int  g;
    bit  full, empty, e_vld, hs, pop, r0, r1, e_srr;
    @(negedge clk);
    full  = (owner.size() == OSTD);
    empty = (owner.size() == 0);
    if (stalled >= 0)          g = stalled;
    else if (mv[0] && mv[1])   g = fav;
    else                       g = mv[1] ? 1 : 0;
    e_vld = mv[g] && !full;
    chk("slv_req", 128'({slv_req_vld, slv_req_read, slv_req_addr, slv_req_mask, slv_req_data}),
        128'({e_vld, mrd[g], ma[g], mm[g], md[g]}));
    chk("req_rdy", 128'({mst0_req_rdy, mst1_req_rdy}),
        128'({g == 0 && slv_req_rdy && !full, g == 1 && slv_req_rdy && !full}));
    r0 = !empty && owner[0] == 0;
    r1 = !empty && owner[0] == 1;
    e_srr = empty ? 1'b1 : mrr[owner[0]];
    chk("rsp0", 128'({mst0_rsp_vld, mst0_rsp_excp, mst0_rsp_data}),
        128'({r0 && slv_rsp_vld, r0 ? slv_rsp_excp : 2'b00, r0 ? slv_rsp_data : 32'h0}));
    chk("rsp1", 128'({mst1_rsp_vld, mst1_rsp_excp, mst1_rsp_data}),
        128'({r1 && slv_rsp_vld, r1 ? slv_rsp_excp : 2'b00, r1 ? slv_rsp_data : 32'h0}));
    chk("rsp_rdy", 128'(slv_rsp_rdy), 128'(e_srr));
    @(posedge clk);
    hs  = e_vld && slv_req_rdy;
    pop = !empty && slv_rsp_vld && e_srr;
    if (pop) void'(owner.pop_front());
    if (hs) begin
      owner.push_back(g);
      fav = 1 - g;
      stalled = -1;
    end else if (e_vld) begin
      stalled = g;
    end
    for (int x = 0; x < 2; x++) hold[x] = mv[x] && !(hs && g == x);
    #1;
  endtask

  task automatic run(input int n, input int pv, input int ps, input int prv, input int prr);
    for (int i = 0; i < n; i++) begin
      drive(pv, ps, prv, prr);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    all_low();
    model_reset();
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("idle");

    run(30, 100, 100, 0, 0);    // both request, fabric ready, no responses: alternation then full
    run(20, 0, 100, 100, 60);   // drain with response back-pressure
    run(6, 0, 50, 100, 50);     // responses against an empty queue
    run(400, 70, 60, 50, 70);   // mixed traffic
    run(150, 90, 30, 40, 80);   // heavy stalling exercises the grant lock
    run(40, 80, 80, 0, 100);    // fill towards the limit

    // Reset in the middle of traffic.
    rst_n = 1'b0;
    all_low();
    model_reset();
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("postrst");
    run(300, 70, 60, 50, 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
